// File: rtl/puf_sequencer.sv
// puf_sequencer: steps a ring-oscillator PUF bank through NCHAL challenges.
// Each challenge is cleared, measured for WINDOW cycles, drained and
// captured as eight neighbour comparisons packed into one response byte.
// Optional macro PUF_MAJORITY_EN: measure every challenge three times and
// keep the 2-of-3 majority of each response bit.
module puf_sequencer #(
    parameter int WINDOW    = 80000000,
    parameter int CLEAR_CYC = 4,
    parameter int NCHAL     = 8
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic [5:0]   base_chal,
    input  logic [143:0] count,
    output logic [5:0]   ro_chal,
    output logic         ro_enable,
    output logic         ro_reset,
    output logic         busy,
    output logic         done,
    output logic [63:0]  response
);

    localparam int DRAIN_CYC = 4;
    localparam int BIG_CYC   = (WINDOW > CLEAR_CYC) ? WINDOW : CLEAR_CYC;
    localparam int MAX_CYC   = (BIG_CYC > DRAIN_CYC) ? BIG_CYC : DRAIN_CYC;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [2:0]       CHAL_LAST   = 3'(NCHAL - 1);

    // Refuse to elaborate with a challenge count the response cannot hold
    // or with phase lengths that would leave a phase empty.
    generate
        if (NCHAL < 1 || NCHAL > 8) begin : g_bad_nchal
            $error("puf_sequencer: NCHAL must be in 1..8");
        end
        if (WINDOW < 1 || CLEAR_CYC < 1) begin : g_bad_timing
            $error("puf_sequencer: WINDOW and CLEAR_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        DRAIN,
        CAPTURE,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [2:0]         idx;
    logic [5:0]         base_q;
    logic [63:0]        response_q;
    logic [7:0]         cur_bits;
    logic [7:0]         final_bits;
    logic               last_pass;
    logic               last_chal;

    assign last_chal = (idx == CHAL_LAST);
    assign ro_chal   = base_q + {3'b000, idx};
    assign response  = response_q;

    // Compare each oscillator with its right-hand neighbour; ties read as 0.
    always_comb begin
        cur_bits = '0;
        for (int j = 0; j < 8; j++) begin
            cur_bits[j] = (count[16*j +: 16] > count[16*(j+1) +: 16]);
        end
    end

`ifdef PUF_MAJORITY_EN
    logic [1:0] pass_q;
    logic [7:0] pass0_q;
    logic [7:0] pass1_q;

    assign last_pass  = (pass_q == 2'd2);
    assign final_bits = (pass0_q & pass1_q) | (pass0_q & cur_bits) | (pass1_q & cur_bits);

    // Keep the first two passes of a challenge so the third can vote.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pass_q  <= 2'd0;
            pass0_q <= '0;
            pass1_q <= '0;
        end else if (state == IDLE && start) begin
            pass_q <= 2'd0;
        end else if (state == CAPTURE) begin
            if (last_pass) begin
                pass_q <= 2'd0;
            end else begin
                pass_q <= pass_q + 2'd1;
                if (pass_q == 2'd0) begin
                    pass0_q <= cur_bits;
                end else begin
                    pass1_q <= cur_bits;
                end
            end
        end
    end
`else
    assign last_pass  = 1'b1;
    assign final_bits = cur_bits;
`endif

    // State register; reset returns to IDLE from anywhere, even mid-window.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phase sequencing and the RO bank control lines derived from the phase.
    always_comb begin
        next_state = state;
        ro_enable  = 1'b0;
        ro_reset   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                ro_reset = 1'b1;
                busy     = 1'b1;
                if (cyc_cnt == CLEAR_LAST) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                ro_enable = 1'b1;
                busy      = 1'b1;
                if (cyc_cnt == WINDOW_LAST) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cyc_cnt == DRAIN_LAST) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (last_pass && last_chal) begin
                    next_state = DONE;
                end else begin
                    next_state = CLEAR;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase cycle counter, challenge index, latched base and packed response.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cyc_cnt    <= '0;
            idx        <= 3'd0;
            base_q     <= 6'd0;
            response_q <= '0;
        end else begin
            if (state == IDLE || next_state != state) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_chal;
                        idx        <= 3'd0;
                        response_q <= '0;
                    end
                end
                CAPTURE: begin
                    if (last_pass) begin
                        response_q[{idx, 3'b000} +: 8] <= final_bits;
                        if (!last_chal) begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/puf_sequencer.md
PUF_SEQUENCER -- requirements
Module: puf_sequencer

Interface
REQ-001 SHALL have parameter WINDOW, default 80000000, meaning the number of CLK cycles ro_enable is held high per measurement.
REQ-002 SHALL have parameter CLEAR_CYC, default 4, meaning the number of CLK cycles ro_reset is held high before each measurement.
REQ-003 SHALL have parameter NCHAL, default 8, legal range 1..8, meaning the number of challenges per run; an illegal value SHALL be an elaboration error.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports: CLK in 1 (clock), reset in 1 (synchronous active-high reset).
REQ-005 SHALL have port start in 1: request a run; sampled only in IDLE.
REQ-006 SHALL have port base_chal in 6: first challenge, {sel[2:0],bx[2:0]}.
REQ-007 SHALL have port count in 144: nine 16-bit RO counts; RO k occupies bits [16k+15:16k].
REQ-008 SHALL have port ro_chal out 6: challenge driven to the RO bank.
REQ-009 SHALL have ports ro_enable out 1 (RO bank enable) and ro_reset out 1 (RO counter clear).
REQ-010 SHALL have ports busy out 1 (run in progress) and done out 1 (one-cycle pulse at run end).
REQ-011 SHALL have port response out 64: packed response bits.

Function
REQ-012 SHALL implement states IDLE, CLEAR, MEASURE, DRAIN, CAPTURE; DONE is a single-cycle state.
REQ-013 In IDLE with start=1, SHALL latch base_chal, clear response to 0, set index i=0, and enter CLEAR; busy SHALL be 1 from the next cycle.
REQ-014 ro_chal SHALL equal (base_chal+i) mod 64 and SHALL be stable from entry to CLEAR through CAPTURE of that challenge; wrap 6'h3F->6'h00.
REQ-015 CLEAR: ro_reset=1, ro_enable=0 for exactly CLEAR_CYC cycles, then MEASURE.
REQ-016 MEASURE: ro_enable=1, ro_reset=0 for exactly WINDOW cycles, then DRAIN.
REQ-017 DRAIN: ro_enable=0 for exactly 4 cycles, allowing asynchronous RO counters to settle, then CAPTURE.
REQ-018 CAPTURE (1 cycle) SHALL compute bit j (j=0..7) = (count RO j > count RO j+1), unsigned; equal counts SHALL give 0.
REQ-019 CAPTURE SHALL write these bits to response[8i+7:8i]; unused bytes SHALL stay 0.
REQ-020 After CAPTURE: if i<NCHAL-1, SHALL increment i and go to CLEAR; otherwise SHALL go to DONE.
REQ-021 DONE: done=1 for one cycle and busy=0 in that same cycle, then IDLE.
REQ-022 Per measurement pass, latency SHALL be CLEAR_CYC+WINDOW+5 cycles.
REQ-023 start while not in IDLE (including DONE) SHALL be ignored.
REQ-024 In IDLE, ro_enable=0 and ro_reset=0, so that counts remain readable for display.
REQ-025 response SHALL hold its value from DONE until the next accepted start.

Reset
REQ-026 reset=1 at a rising CLK edge SHALL force IDLE from any state, including mid-MEASURE.
REQ-027 On reset, outputs SHALL take the values busy=0, done=0, response=0, ro_chal=0, ro_enable=0, ro_reset=0, and i=0.

Configuration
REQ-028 Macro PUF_MAJORITY_EN: when defined, each challenge SHALL run CLEAR/MEASURE/DRAIN/CAPTURE three times, and each response bit SHALL be the 2-of-3 majority; ro_chal SHALL be constant across the three passes.
REQ-029 Without PUF_MAJORITY_EN, each challenge SHALL be measured once and the majority logic SHALL be absent.

Verification (WINDOW=16, CLEAR_CYC=2)
REQ-030 Reset: after reset, all outputs are 0 and no transition occurs without start.
REQ-031 Single challenge: NCHAL=1, base_chal=6'h05, counts RO k=200-10k, start pulse -> ro_chal=6'h05, ro_reset high 2 cycles, ro_enable high exactly 16 cycles, done 23 cycles after CLEAR entry, response=64'h00000000000000FF.
REQ-032 Ties: all counts=16'h1234 -> response[7:0]=8'h00; counts RO k=10k -> response[7:0]=8'h00.
REQ-033 Wrap: NCHAL=8, base_chal=6'h3E -> ro_chal sequence 3E,3F,00,01,02,03,04,05; done once; busy is continuous for 8x23 cycles.
REQ-034 Abuse: start pulsed mid-run -> ignored, same done time. reset asserted in MEASURE -> next cycle IDLE, ro_enable=0, response=0.
REQ-035 With PUF_MAJORITY_EN: counts give bit0=1 on passes 1 and 3 and bit0=0 on pass 2 -> response[0]=1; done at 69 cycles per challenge.
